// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: steps subbytes/shiftrows/mixcolumns/addroundkey per round; done follows start by 4*NR edges.
// Holds in INIT/ARK while key_rdy is low; start is only taken while ready, abort cancels any running block.
module aes_round_ctrl #(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          key_rdy,
    output logic          ready,
    output logic          busy,
    output logic          done,
    output logic          sel_init,
    output logic          sub_ena,
    output logic          shift_ena,
    output logic          mix_ena,
    output logic          ark_ena,
    output logic [RW-1:0] key_idx
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_SUB   = 3'd2,
        S_SHIFT = 3'd3,
        S_MIX   = 3'd4,
        S_ARK   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [RW-1:0] NR_C  = RW'(NR);
    localparam logic [RW-1:0] ONE_C = RW'(1);

    state_t        state, state_nxt;
    logic [RW-1:0] round, round_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            round <= '0;
        end else begin
            state <= state_nxt;
            round <= round_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        round_nxt = round;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        sel_init  = 1'b0;
        sub_ena   = 1'b0;
        shift_ena = 1'b0;
        mix_ena   = 1'b0;
        ark_ena   = 1'b0;
        key_idx   = '0;

        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = S_INIT;
                    round_nxt = '0;
                end
            end

            S_INIT: begin
                busy     = 1'b1;
                sel_init = 1'b1;
                if (abort) begin
                    state_nxt = S_IDLE;
                    round_nxt = '0;
                end else begin
                    ark_ena = key_rdy;
                    if (key_rdy) begin
                        state_nxt = S_SUB;
                        round_nxt = ONE_C;
                    end
                end
            end

            // Key index tracks the current round through the whole round so the
            // key schedule can have the next key ready by the time ARK arrives.
            S_SUB: begin
                busy    = 1'b1;
                key_idx = round;
                if (abort) begin
                    state_nxt = S_IDLE;
                    round_nxt = '0;
                end else begin
                    sub_ena   = 1'b1;
                    state_nxt = S_SHIFT;
                end
            end

            S_SHIFT: begin
                busy    = 1'b1;
                key_idx = round;
                if (abort) begin
                    state_nxt = S_IDLE;
                    round_nxt = '0;
                end else begin
                    shift_ena = 1'b1;
                    state_nxt = (round >= NR_C) ? S_ARK : S_MIX;
                end
            end

            S_MIX: begin
                busy    = 1'b1;
                key_idx = round;
                if (abort) begin
                    state_nxt = S_IDLE;
                    round_nxt = '0;
                end else begin
                    mix_ena   = 1'b1;
                    state_nxt = S_ARK;
                end
            end

            S_ARK: begin
                busy    = 1'b1;
                key_idx = round;
                if (abort) begin
                    state_nxt = S_IDLE;
                    round_nxt = '0;
                end else begin
                    ark_ena = key_rdy;
                    if (key_rdy) begin
                        if (round >= NR_C) begin
                            state_nxt = S_DONE;
                        end else begin
                            state_nxt = S_SUB;
                            round_nxt = round + ONE_C;
                        end
                    end
                end
            end

            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
                round_nxt = '0;
            end

            default: begin
                state_nxt = S_IDLE;
                round_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Drives two controllers (NR=10 and NR=14) from shared inputs and compares every cycle
// against a per-block operation schedule built from the round rules.
module tb_aes_round_ctrl;

    localparam int OP_INIT  = 1;
    localparam int OP_SUB   = 2;
    localparam int OP_SHIFT = 3;
    localparam int OP_MIX   = 4;
    localparam int OP_ARK   = 5;
    localparam int OP_DONE  = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic key_rdy = 1'b1;

    // {ready, busy, done, sel_init, sub, shift, mix, ark, key_idx[3:0]}
    wire [11:0] o10;
    wire [11:0] o14;

    always #5 clk = ~clk;

    aes_round_ctrl #(.NR(10), .RW(4)) u_d10 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .key_rdy(key_rdy),
        .ready(o10[11]), .busy(o10[10]), .done(o10[9]), .sel_init(o10[8]),
        .sub_ena(o10[7]), .shift_ena(o10[6]), .mix_ena(o10[5]), .ark_ena(o10[4]),
        .key_idx(o10[3:0])
    );

    aes_round_ctrl #(.NR(14), .RW(4)) u_d14 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .key_rdy(key_rdy),
        .ready(o14[11]), .busy(o14[10]), .done(o14[9]), .sel_init(o14[8]),
        .sub_ena(o14[7]), .shift_ena(o14[6]), .mix_ena(o14[5]), .ark_ena(o14[4]),
        .key_idx(o14[3:0])
    );

    int op  [2][64];
    int rnd [2][64];
    int len [2];
    int pos [2];
    int nrs [2] = '{10, 14};
    int total = 0;
    int bad = 0;
    int edge_cnt = 0;
    int acc_edge [2];
    int done_edge [2];
    int done_cnt [2] = '{0, 0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [11:0] expv(input int d);
        logic [11:0] v;
        logic go;
        int o;
        v  = '0;
        go = !abort;
        if (pos[d] < 0) begin
            v[11] = 1'b1;
        end else begin
            o = op[d][pos[d]];
            v[3:0] = 4'(rnd[d][pos[d]]);
            v[10]  = (o != OP_DONE);
            case (o)
                OP_INIT:  begin v[8] = 1'b1; v[4] = key_rdy && go; end
                OP_SUB:   v[7] = go;
                OP_SHIFT: v[6] = go;
                OP_MIX:   v[5] = go;
                OP_ARK:   v[4] = key_rdy && go;
                OP_DONE:  v[9] = 1'b1;
                default:  v = '1;
            endcase
        end
        return v;
    endfunction

    task automatic adv(input int d);
        int o;
        if (rst) begin
            pos[d] = -1;
        end else if (pos[d] < 0) begin
            if (start) begin
                pos[d] = 0;
                acc_edge[d] = edge_cnt;
            end
        end else begin
            o = op[d][pos[d]];
            if (o == OP_DONE || abort)
                pos[d] = -1;
            else if (!((o == OP_INIT || o == OP_ARK) && !key_rdy))
                pos[d] = pos[d] + 1;
        end
    endtask

    task automatic tick();
        #1;
        check("cyc_d10", 32'(o10), 32'(expv(0)));
        check("cyc_d14", 32'(o14), 32'(expv(1)));
        if (o10[9]) begin done_edge[0] = edge_cnt; done_cnt[0]++; end
        if (o14[9]) begin done_edge[1] = edge_cnt; done_cnt[1]++; end
        @(posedge clk);
        edge_cnt++;
        adv(0);
        adv(1);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && !(pos[0] < 0 && pos[1] < 0); i++) tick();
        check("idle_reached", 32'(pos[0] < 0 && pos[1] < 0), 32'd1);
        tick();
    endtask

    function automatic int cur_op(input int d);
        return (pos[d] < 0) ? 0 : op[d][pos[d]];
    endfunction

    initial begin
        int n;
        int dc;
        int dc14;
        int s_init;
        int s_ark;
        int prev10;
        int prev14;

        for (int d = 0; d < 2; d++) begin
            n = 0;
            op[d][n] = OP_INIT; rnd[d][n] = 0; n++;
            for (int r = 1; r <= nrs[d]; r++) begin
                op[d][n] = OP_SUB;   rnd[d][n] = r; n++;
                op[d][n] = OP_SHIFT; rnd[d][n] = r; n++;
                if (r < nrs[d]) begin op[d][n] = OP_MIX; rnd[d][n] = r; n++; end
                op[d][n] = OP_ARK;   rnd[d][n] = r; n++;
            end
            op[d][n] = OP_DONE; rnd[d][n] = 0; n++;
            len[d] = n;
            pos[d] = -1;
        end

        // reset
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_d10", 32'(o10), 32'h800);
        check("rst_d14", 32'(o14), 32'h800);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // single start pulse, keys always ready
        done_edge = '{-1000, -1000};
        dc = done_cnt[0];
        dc14 = done_cnt[1];
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100 && done_cnt[1] == dc14; i++) tick();
        check("lat_d10", 32'(done_edge[0] - acc_edge[0]), 32'd40);
        check("lat_d14", 32'(done_edge[1] - acc_edge[1]), 32'd56);
        check("one_done_d10", 32'(done_cnt[0] - dc), 32'd1);
        wait_idle();

        // key stalls: 3 cycles in INIT, 2 cycles in ARK of round 5
        done_edge[0] = -1000;
        dc = done_cnt[0];
        s_init = 0;
        s_ark = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100 && done_cnt[0] == dc; i++) begin
            key_rdy = 1'b1;
            if (cur_op(0) == OP_INIT && s_init < 3) begin key_rdy = 1'b0; s_init++; end
            if (cur_op(0) == OP_ARK && rnd[0][pos[0]] == 5 && s_ark < 2) begin
                key_rdy = 1'b0;
                s_ark++;
            end
            tick();
        end
        key_rdy = 1'b1;
        check("lat_stall_d10", 32'(done_edge[0] - acc_edge[0]), 32'd45);
        wait_idle();

        // abort in MIX of round 3, then a clean run
        dc = done_cnt[0];
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40 && !(cur_op(0) == OP_MIX && rnd[0][pos[0]] == 3); i++) tick();
        check("reach_mix3", 32'(cur_op(0)), 32'(OP_MIX));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_ready", 32'(o10[11]), 32'd1);
        for (int i = 0; i < 60; i++) tick();
        check("abort_no_done", 32'(done_cnt[0] - dc), 32'd0);
        done_edge[0] = -1000;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100 && done_cnt[0] == dc; i++) tick();
        check("lat_after_abort", 32'(done_edge[0] - acc_edge[0]), 32'd40);
        wait_idle();

        // start held high: back-to-back blocks
        prev10 = -1;
        prev14 = -1;
        dc = done_cnt[0];
        dc14 = done_cnt[1];
        start = 1'b1;
        for (int i = 0; i < 240; i++) begin
            tick();
            if (done_cnt[0] != dc) begin
                if (prev10 >= 0) check("b2b_d10", 32'(done_edge[0] - prev10), 32'd42);
                prev10 = done_edge[0];
                dc = done_cnt[0];
            end
            if (done_cnt[1] != dc14) begin
                if (prev14 >= 0) check("b2b_d14", 32'(done_edge[1] - prev14), 32'd58);
                prev14 = done_edge[1];
                dc14 = done_cnt[1];
            end
        end
        start = 1'b0;
        wait_idle();

        // random start/abort/key availability
        for (int i = 0; i < 1500; i++) begin
            start   = ($urandom_range(0, 3) == 0);
            abort   = ($urandom_range(0, 63) == 0);
            key_rdy = ($urandom_range(0, 3) != 0);
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        key_rdy = 1'b1;
        wait_idle();

        // asynchronous reset between edges while in SHIFT
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20 && cur_op(0) != OP_SHIFT; i++) tick();
        check("reach_shift", 32'(cur_op(0)), 32'(OP_SHIFT));
        #2;
        rst = 1'b1;
        #1;
        check("arst_d10", 32'(o10), 32'h800);
        check("arst_d14", 32'(o14), 32'h800);
        pos = '{-1, -1};
        dc = done_cnt[0];
        dc14 = done_cnt[1];
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("arst_no_done10", 32'(done_cnt[0] - dc), 32'd0);
        check("arst_no_done14", 32'(done_cnt[1] - dc14), 32'd0);

        // NR=14 rerun after reset
        done_edge[1] = -1000;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100 && done_cnt[1] == dc14; i++) tick();
        check("lat_rerun_d14", 32'(done_edge[1] - acc_edge[1]), 32'd56);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
